ca_sequencer: RTL and testbench

Command-driven controller that sequences the 128-cell Rule 110 cell array through its pin-level control interface. It uploads a seed row from a byte stream, advances the automaton by a programmed number of generations, and streams rows back out as bytes, so that a host no longer toggles the write-enable, halt and address pins by hand. It sits between the host-side command/stream ports and the cell array's data-in, data-out, write-enable, halt and block-address pins.

---
 rtl/ca_sequencer_pkg.sv | 22 ++
 rtl/ca_block_walker.sv | 24 ++
 rtl/ca_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_ca_sequencer.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ca_sequencer_pkg.sv
// Shared definitions for ca_sequencer: command codes, FSM states, array address width.
// ST_RUN_DUMP / ST_RUN_ADV are only reached when CA_SEQ_TRACE_EN is defined.
package ca_sequencer_pkg;

  localparam int unsigned ADDR_W = 6;

  localparam logic [1:0] CMD_LOAD  = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_RUN      = 3'd2,
    ST_READ     = 3'd3,
    ST_CLEAR    = 3'd4,
    ST_RUN_DUMP = 3'd5,
    ST_RUN_ADV  = 3'd6
  } state_e;

endpackage

// File: rtl/ca_block_walker.sv
// Block-index counter shared by every row walk; wraps to 0 after the last block.
module ca_block_walker #(
  parameter int unsigned NUM_BLOCKS = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_BLOCKS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [IDX_W-1:0] idx,
  output logic             last_c
);

  assign last_c = (idx == IDX_W'(NUM_BLOCKS - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx <= '0;
    end else if (step) begin
      idx <= last_c ? '0 : idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/ca_sequencer.sv
// Command sequencer for the 128-cell Rule 110 array: LOAD / RUN / READ / CLEAR.
// Define CA_SEQ_TRACE_EN to make RUN stream every intermediate row (RUN_DUMP/RUN_ADV).
module ca_sequencer
  import ca_sequencer_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS = 16,
  parameter int unsigned GEN_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [GEN_W-1:0]  cmd_arg,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic [7:0]        ca_data_in,
  output logic              ca_we_n,
  output logic              ca_halt_n,
  output logic [ADDR_W-1:0] ca_addr,
  input  logic [7:0]        ca_data_out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);

  state_e           state;
  state_e           state_nx;
  logic             done_nx;
  logic [GEN_W-1:0] gen_cnt;
  logic [IDX_W-1:0] blk_idx;
  logic             blk_last_c;
  logic             blk_step_c;
  logic             blk_clear_c;
  logic             stream_c;

  ca_block_walker #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .IDX_W      (IDX_W)
  ) u_walker (
    .clk    (clk),
    .reset  (reset),
    .clear  (blk_clear_c),
    .step   (blk_step_c),
    .idx    (blk_idx),
    .last_c (blk_last_c)
  );

`ifdef CA_SEQ_TRACE_EN
  assign stream_c = (state == ST_READ) || (state == ST_RUN_DUMP);
`else
  assign stream_c = (state == ST_READ);
`endif
  assign blk_clear_c = (state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next state plus the completion pulse raised on every return to IDLE.
  always_comb begin
    state_nx = state;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            CMD_LOAD:  state_nx = ST_LOAD;
            CMD_READ:  state_nx = ST_READ;
            CMD_CLEAR: state_nx = ST_CLEAR;
            default: begin
              if (cmd_arg == '0) begin
                done_nx = 1'b1;
              end else begin
`ifdef CA_SEQ_TRACE_EN
                state_nx = ST_RUN_DUMP;
`else
                state_nx = ST_RUN;
`endif
              end
            end
          endcase
        end
      end
      ST_LOAD: begin
        if (in_valid && blk_last_c) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (blk_last_c) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
      ST_READ: begin
        if (out_ready && blk_last_c) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
`ifdef CA_SEQ_TRACE_EN
      ST_RUN_DUMP: begin
        if (out_ready && blk_last_c) state_nx = ST_RUN_ADV;
      end
      ST_RUN_ADV: begin
        if (gen_cnt <= GEN_W'(1)) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = ST_RUN_DUMP;
        end
      end
`else
      ST_RUN: begin
        if (gen_cnt <= GEN_W'(1)) begin
          state_nx = ST_IDLE;
          done_nx  = 1'b1;
        end
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  // Array pin drive and stream handshakes; the array is halted unless advancing.
  always_comb begin
    cmd_ready  = (state == ST_IDLE);
    busy       = (state != ST_IDLE);
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    out_data   = 8'h00;
    ca_data_in = 8'h00;
    ca_we_n    = 1'b1;
    ca_halt_n  = 1'b0;
    ca_addr    = '0;
    blk_step_c = 1'b0;
    if (stream_c) begin
      out_valid  = 1'b1;
      out_last   = blk_last_c;
      out_data   = ca_data_out;
      ca_addr    = ADDR_W'(blk_idx);
      blk_step_c = out_ready;
    end
    case (state)
      ST_LOAD: begin
        in_ready   = 1'b1;
        ca_addr    = ADDR_W'(blk_idx);
        ca_data_in = in_valid ? in_data : 8'h00;
        ca_we_n    = ~in_valid;
        blk_step_c = in_valid;
      end
      ST_CLEAR: begin
        ca_addr    = ADDR_W'(blk_idx);
        ca_we_n    = 1'b0;
        blk_step_c = 1'b1;
      end
`ifdef CA_SEQ_TRACE_EN
      ST_RUN_ADV: ca_halt_n = 1'b1;
`else
      ST_RUN:     ca_halt_n = 1'b1;
`endif
      default: ;
    endcase
  end

  // Generation counter: loaded on RUN accept, counts down once per advance cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen_cnt <= '0;
    end else if ((state == ST_IDLE) && cmd_valid && (cmd_op == CMD_RUN)) begin
      gen_cnt <= cmd_arg;
    end else if (ca_halt_n && (gen_cnt != '0)) begin
      gen_cnt <= gen_cnt - GEN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) done <= 1'b0;
    else       done <= done_nx;
  end

endmodule

// File: tb/tb_ca_sequencer.sv
// Directed bench: ca_sequencer driving a behavioural 128-cell Rule 110 array (wrap-around).
module tb_ca_sequencer;
  import ca_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_arg;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [7:0]  ca_data_in;
  logic        ca_we_n;
  logic        ca_halt_n;
  logic [5:0]  ca_addr;
  logic [7:0]  ca_data_out;
  logic        busy;
  logic        done;

  logic         arr_rst;
  logic [127:0] cells;
  logic [127:0] cells_nx;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] cap  [64];
  logic       capl [64];

  always #5 clk = ~clk;

  ca_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .ca_data_in (ca_data_in),
    .ca_we_n    (ca_we_n),
    .ca_halt_n  (ca_halt_n),
    .ca_addr    (ca_addr),
    .ca_data_out(ca_data_out),
    .busy       (busy),
    .done       (done)
  );

  // Cell i sees cell i+1 on its left and cell i-1 on its right.
  function automatic logic [127:0] rule110_next(input logic [127:0] c);
    logic [7:0]   rule;
    logic [127:0] n;
    logic [6:0]   il;
    logic [6:0]   ic;
    logic [6:0]   ir;
    rule = 8'd110;
    for (int i = 0; i < 128; i++) begin
      il = 7'(i + 1);
      ic = 7'(i);
      ir = 7'(i + 127);
      n[ic] = rule[{c[il], c[ic], c[ir]}];
    end
    return n;
  endfunction

  always_comb begin
    cells_nx    = rule110_next(cells);
    ca_data_out = cells_nx[{ca_addr[3:0], 3'b000} +: 8];
  end

  always @(posedge clk) begin
    if (arr_rst)         cells <= '0;
    else if (!ca_we_n)   cells[{ca_addr[3:0], 3'b000} +: 8] <= ca_data_in;
    else if (ca_halt_n)  cells <= cells_nx;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] op, input logic [15:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    #1;
    check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic load_row(input logic [127:0] row);
    issue(CMD_LOAD, 16'd0);
    for (int i = 0; i < 16; i++) begin
      if (i == 5) begin
        in_valid = 1'b0;
        #1;
        check("ld_gap_we_n", 32'(ca_we_n), 32'd1);
        check("ld_gap_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = row[i*8 +: 8];
      #1;
      check("ld_we_n", 32'(ca_we_n), 32'd0);
      check("ld_addr", 32'(ca_addr), 32'(i));
      check("ld_data_in", 32'(ca_data_in), 32'(row[i*8 +: 8]));
      check("ld_halt_n", 32'(ca_halt_n), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #1;
    check("ld_done", 32'(done), 32'd1);
    check("ld_idle_busy", 32'(busy), 32'd0);
    check("ld_idle_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ld_done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic read_row(input logic [127:0] exp, input bit stall);
    issue(CMD_READ, 16'd0);
    for (int i = 0; i < 16; i++) begin
      if (stall) begin
        out_ready = 1'b0;
        #1;
        check("rd_stall_valid", 32'(out_valid), 32'd1);
        check("rd_stall_data", 32'(out_data), 32'(exp[i*8 +: 8]));
        check("rd_stall_addr", 32'(ca_addr), 32'(i));
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
      #1;
      check("rd_data", 32'(out_data), 32'(exp[i*8 +: 8]));
      check("rd_addr", 32'(ca_addr), 32'(i));
      check("rd_last", 32'(out_last), 32'(i == 15));
      check("rd_halt_n", 32'(ca_halt_n), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    #1;
    check("rd_done", 32'(done), 32'd1);
    check("rd_end_valid", 32'(out_valid), 32'd0);
    check("rd_end_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    check("rd_done_one_cycle", 32'(done), 32'd0);
  endtask

  // Returns after the done cycle; captures any streamed bytes into cap/capl.
  task automatic run_g(input int g, input int exp_bytes, input int exp_done);
    int halts;
    int nbytes;
    int done_at;
    int we_low;
    halts = 0; nbytes = 0; done_at = 0; we_low = 0;
    issue(CMD_RUN, 16'(g));
    out_ready = 1'b1;
    for (int c = 1; c <= exp_done + 8; c++) begin
      #1;
      if (done) begin
        done_at = c;
        break;
      end
      if (ca_halt_n) halts++;
      if (!ca_we_n)  we_low++;
      if (out_valid && nbytes < 64) begin
        cap[nbytes]  = out_data;
        capl[nbytes] = out_last;
        nbytes++;
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b0;
    check("run_done_cycle", 32'(done_at), 32'(exp_done));
    check("run_halt_cycles", 32'(halts), 32'(g));
    check("run_bytes", 32'(nbytes), 32'(exp_bytes));
    check("run_we_low", 32'(we_low), 32'd0);
    check("run_cmd_ready", 32'(cmd_ready), 32'd1);
    check("run_halt_at_done", 32'(ca_halt_n), 32'd0);
    @(posedge clk); #1;
    check("run_done_one_cycle", 32'(done), 32'd0);
  endtask

  task automatic clear_all();
    issue(CMD_CLEAR, 16'd0);
    for (int i = 0; i < 16; i++) begin
      #1;
      check("clr_we_n", 32'(ca_we_n), 32'd0);
      check("clr_addr", 32'(ca_addr), 32'(i));
      check("clr_data_in", 32'(ca_data_in), 32'd0);
      @(posedge clk); #1;
    end
    #1;
    check("clr_done", 32'(done), 32'd1);
    check("clr_halt_n", 32'(ca_halt_n), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset     = 1'b1;
    arr_rst   = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_arg   = 16'd0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset   = 1'b0;
    arr_rst = 1'b0;
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_halt_n", 32'(ca_halt_n), 32'd0);
    check("rst_we_n", 32'(ca_we_n), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_addr", 32'(ca_addr), 32'd0);
    check("rst_data_in", 32'(ca_data_in), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("idle_no_done", 32'(done), 32'd0);
      @(posedge clk); #1;
    end

    load_row(128'h01);
`ifdef CA_SEQ_TRACE_EN
    run_g(2, 32, 35);
    check("tr_r1_b0", 32'(cap[0]), 32'h03);
    check("tr_r1_b1", 32'(cap[1]), 32'h00);
    check("tr_r1_last", 32'(capl[15]), 32'd1);
    check("tr_r1_b0_last", 32'(capl[0]), 32'd0);
    check("tr_r2_b0", 32'(cap[16]), 32'h07);
    check("tr_r2_b15", 32'(cap[31]), 32'h00);
    check("tr_r2_last", 32'(capl[31]), 32'd1);
    read_row(128'h0D, 1'b0);
    run_g(0, 0, 1);
    read_row(128'h0D, 1'b1);
`else
    read_row(128'h03, 1'b0);
    read_row(128'h03, 1'b1);
    run_g(1, 0, 2);
    read_row(128'h07, 1'b0);
    run_g(0, 0, 1);
    read_row(128'h07, 1'b0);
    run_g(3, 0, 4);
    read_row(128'h31, 1'b1);
`endif

    clear_all();
    read_row(128'h00, 1'b0);

    // Reset in the middle of a LOAD after three bytes.
    issue(CMD_LOAD, 16'd0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hA0 + 8'(i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    reset    = 1'b1;
    @(posedge clk); #1;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_no_done", 32'(done), 32'd0);
    load_row(128'h01);
    read_row(128'h03, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
